bbox_tracker: RTL and testbench

Frame-level bounding-box extractor for the pixel pipeline. Consumes a raster-ordered stream of (hcount, vcount, mask) pixels and accumulates the min/max coordinates and population of mask-set pixels over one frame. At frame end it reports x, y, width and height in exactly the form the rectangle renderer accepts, closing the loop from detected region back to on-screen box.

---
 rtl/bbox_tracker.sv | 123 ++++++++++++
 tb/tb_bbox_tracker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bbox_tracker.sv
// rtl/bbox_tracker.sv - frame-level bounding-box extractor for a raster pixel stream
module bbox_tracker #(
   parameter int H_ACTIVE   = 1280,
   parameter int V_ACTIVE   = 720,
   parameter int MIN_PIXELS = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        data_valid_in,
   input  logic        mask_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic [10:0] width_out,
   output logic [9:0]  height_out,
   output logic [19:0] count_out,
   output logic        found_out,
   output logic        valid_out
);

   localparam logic [11:0] H_LIM   = 12'(H_ACTIVE);
   localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
   localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
   localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);

   typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
   state_t state;

   logic [10:0] min_x, max_x;
   logic [9:0]  min_y, max_y;
   logic [19:0] count;

   logic        accepted, is_start, is_last, fold, load;
   logic [10:0] base_min_x, base_max_x, nxt_min_x, nxt_max_x;
   logic [9:0]  base_min_y, base_max_y, nxt_min_y, nxt_max_y;
   logic [19:0] base_count, nxt_count;

   // Qualify the pixel and fold it into either the live or freshly cleared accumulators
   always_comb begin
      accepted = data_valid_in && ({1'b0, hcount_in} < H_LIM) && ({1'b0, vcount_in} < V_LIM);
      is_start = accepted && (hcount_in == '0) && (vcount_in == '0);
      is_last  = accepted && (hcount_in == X_LAST) && (vcount_in == Y_LAST);
      fold     = accepted && mask_in;
      load     = is_start || (state == ACCUM);
      if (is_start) begin
         base_min_x = X_LAST;
         base_max_x = '0;
         base_min_y = Y_LAST;
         base_max_y = '0;
         base_count = '0;
      end else begin
         base_min_x = min_x;
         base_max_x = max_x;
         base_min_y = min_y;
         base_max_y = max_y;
         base_count = count;
      end
      nxt_min_x = (fold && (hcount_in < base_min_x)) ? hcount_in : base_min_x;
      nxt_max_x = (fold && (hcount_in > base_max_x)) ? hcount_in : base_max_x;
      nxt_min_y = (fold && (vcount_in < base_min_y)) ? vcount_in : base_min_y;
      nxt_max_y = (fold && (vcount_in > base_max_y)) ? vcount_in : base_max_y;
      nxt_count = (fold && (base_count != '1)) ? base_count + 20'd1 : base_count;
   end

   // Accumulators: restart on every frame-start, track pixels while accumulating, else frozen
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         min_x <= X_LAST;
         max_x <= '0;
         min_y <= Y_LAST;
         max_y <= '0;
         count <= '0;
      end else if (load) begin
         min_x <= nxt_min_x;
         max_x <= nxt_max_x;
         min_y <= nxt_min_y;
         max_y <= nxt_max_y;
         count <= nxt_count;
      end
   end

   // Frame FSM; the report registers load on the frame-last edge so they are live during REPORT
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= IDLE;
         valid_out  <= 1'b0;
         found_out  <= 1'b0;
         count_out  <= '0;
         x_out      <= '0;
         y_out      <= '0;
         width_out  <= '0;
         height_out <= '0;
      end else begin
         valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (is_start) state <= ACCUM;
            end
            ACCUM: begin
               if (is_last && !is_start) begin
                  state     <= REPORT;
                  valid_out <= 1'b1;
                  count_out <= nxt_count;
                  found_out <= (nxt_count >= MIN_CNT);
                  if (nxt_count >= MIN_CNT) begin
                     x_out      <= nxt_min_x;
                     y_out      <= nxt_min_y;
                     width_out  <= nxt_max_x - nxt_min_x + 11'd1;
                     height_out <= nxt_max_y - nxt_min_y + 10'd1;
                  end
               end
            end
            REPORT: begin
               state <= is_start ? ACCUM : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bbox_tracker.sv
// tb/tb_bbox_tracker.sv - scoreboard bench for bbox_tracker
module tb_bbox_tracker;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic        data_valid_in;
   logic        mask_in;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic [10:0] width_out;
   logic [9:0]  height_out;
   logic [19:0] count_out;
   logic        found_out;
   logic        valid_out;

   typedef struct {
      int x;
      int y;
      int w;
      int h;
      int cnt;
      int found;
   } rep_t;

   rep_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   bbox_tracker dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .hcount_in     (hcount_in),
      .vcount_in     (vcount_in),
      .data_valid_in (data_valid_in),
      .mask_in       (mask_in),
      .x_out         (x_out),
      .y_out         (y_out),
      .width_out     (width_out),
      .height_out    (height_out),
      .count_out     (count_out),
      .found_out     (found_out),
      .valid_out     (valid_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int x, input int y, input int w, input int h, input int cnt, input int found);
      rep_t r;
      r.x = x; r.y = y; r.w = w; r.h = h; r.cnt = cnt; r.found = found;
      sb.push_back(r);
   endtask

   task automatic check_out();
      rep_t e;
      if (valid_out === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 32'(valid_out), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("x_out", 32'(x_out), e.x);
            chk("y_out", 32'(y_out), e.y);
            chk("width_out", 32'(width_out), e.w);
            chk("height_out", 32'(height_out), e.h);
            chk("count_out", 32'(count_out), e.cnt);
            chk("found_out", 32'(found_out), e.found);
         end
      end
   endtask

   task automatic step(input int x, input int y, input logic dv, input logic m);
      hcount_in     = 11'(x);
      vcount_in     = 10'(y);
      data_valid_in = dv;
      mask_in       = m;
      @(posedge clk_in);
      #1;
      check_out();
   endtask

   task automatic drained(input string tag);
      step(0, 0, 1'b0, 1'b0);
      step(0, 0, 1'b0, 1'b0);
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic outs_zero(input string tag);
      chk({tag, "_valid"}, 32'(valid_out), 32'd0);
      chk({tag, "_found"}, 32'(found_out), 32'd0);
      chk({tag, "_count"}, 32'(count_out), 32'd0);
      chk({tag, "_x"}, 32'(x_out), 32'd0);
      chk({tag, "_y"}, 32'(y_out), 32'd0);
      chk({tag, "_w"}, 32'(width_out), 32'd0);
      chk({tag, "_h"}, 32'(height_out), 32'd0);
   endtask

   initial begin
      int lx, ly, lw, lh;
      rst_in = 1'b1;
      hcount_in = '0; vcount_in = '0; data_valid_in = 1'b0; mask_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      outs_zero("reset");
      @(negedge clk_in);
      rst_in = 1'b0;

      // Single rectangle, with rejected out-of-range and invalid pixels mixed in
      step(0, 0, 1'b1, 1'b0);
      step(1300, 60, 1'b1, 1'b1);
      step(50, 800, 1'b1, 1'b1);
      step(5, 5, 1'b0, 1'b1);
      step(600, 600, 1'b1, 1'b0);
      for (int y = 50; y <= 177; y++)
         for (int x = 100; x <= 227; x++)
            step(x, y, 1'b1, 1'b1);
      push(100, 50, 128, 128, 16384, 1);
      step(1279, 719, 1'b1, 1'b0);
      drained("t1_drained");

      // Sparse frame below threshold keeps the previous box
      step(0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(300 + i, 300, 1'b1, 1'b1);
      push(100, 50, 128, 128, 10, 0);
      step(1279, 719, 1'b1, 1'b0);
      drained("t2_drained");

      // Corner pixels span the full frame
      step(0, 0, 1'b1, 1'b1);
      for (int i = 0; i < 14; i++) step(600 + i, 400, 1'b1, 1'b1);
      push(0, 0, 1280, 720, 16, 1);
      step(1279, 719, 1'b1, 1'b1);
      drained("t3_drained");

      // Frame-last while idle is ignored
      step(1279, 719, 1'b1, 1'b1);
      drained("idle_last_drained");

      // Truncated frame is discarded without a report
      step(0, 0, 1'b1, 1'b0);
      for (int x = 10; x <= 20; x++) step(x, 5, 1'b1, 1'b1);
      step(20, 300, 1'b1, 1'b0);
      step(0, 0, 1'b1, 1'b0);
      for (int y = 400; y <= 415; y++)
         for (int x = 500; x <= 515; x++)
            step(x, y, 1'b1, 1'b1);
      push(500, 400, 16, 16, 256, 1);
      step(1279, 719, 1'b1, 1'b0);
      drained("t4_drained");

      // Back-to-back frames with gaps; each frame-start (0,0) is a mask pixel
      lx = 500; ly = 400; lw = 16; lh = 16;
      for (int f = 0; f < 10; f++) begin
         int x0, y0, w, h, cnt;
         x0 = $urandom_range(1, 1200);
         y0 = $urandom_range(1, 700);
         w  = (f == 9) ? 5 : $urandom_range(1, 6);
         h  = (f == 9) ? 5 : $urandom_range(1, 6);
         cnt = 1 + w * h;
         step(0, 0, 1'b1, 1'b1);
         for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++) begin
               if ($urandom_range(0, 2) == 0)
                  step($urandom_range(0, 1279), $urandom_range(0, 719), 1'b0, 1'b1);
               step(x, y, 1'b1, 1'b1);
            end
         if (cnt >= 16) begin
            lx = 0; ly = 0; lw = x0 + w; lh = y0 + h;
         end
         push(lx, ly, lw, lh, cnt, (cnt >= 16) ? 1 : 0);
         step(1279, 719, 1'b1, 1'b0);
      end
      drained("t5_drained");

      // Asynchronous reset mid-frame
      step(0, 0, 1'b1, 1'b1);
      step(900, 600, 1'b1, 1'b1);
      step(901, 600, 1'b1, 1'b1);
      #2;
      rst_in = 1'b1;
      #1;
      outs_zero("async_rst");
      @(negedge clk_in);
      rst_in = 1'b0;
      step(5, 5, 1'b1, 1'b1);
      step(1279, 719, 1'b1, 1'b1);
      drained("t6_no_report");
      step(0, 0, 1'b1, 1'b0);
      for (int y = 3; y <= 6; y++)
         for (int x = 7; x <= 10; x++)
            step(x, y, 1'b1, 1'b1);
      push(7, 3, 4, 4, 16, 1);
      step(1279, 719, 1'b1, 1'b0);
      drained("t6_drained");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
